fp_div_arbiter: RTL

- Shares one fixed-point divider (WIDTH/FBITS signed, start/busy/valid handshake with dbz/ovf flags) between N_REQ requesters in the LBM datapath, e.g. the density/velocity normalisation units.
- Arbitrates round-robin, latches the winner's operands, and sequences the divider.
- Routes quotient, remainder and flags back to the winner with a one-hot response pulse.
- A watchdog guarantees forward progress if the divider never completes.

---
 rtl/fp_div_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/fp_div_arbiter.sv
// rtl/fp_div_arbiter.sv - round-robin arbiter sharing one fixed-point divider
// between N_REQ requesters, with a watchdog that aborts a stuck division.
module fp_div_arbiter #(
  parameter int WIDTH   = 64,
  parameter int FBITS   = 56,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_x,
  input  logic [N_REQ*WIDTH-1:0] req_y,
  output logic [N_REQ-1:0]       req_ack,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]       resp_q,
  output logic [WIDTH-1:0]       resp_r,
  output logic                   resp_dbz,
  output logic                   resp_ovf,
  output logic                   resp_tmo,
  output logic                   arb_busy,
  output logic                   div_start,
  output logic [WIDTH-1:0]       div_x,
  output logic [WIDTH-1:0]       div_y,
  input  logic                   div_busy,
  input  logic                   div_valid,
  input  logic                   div_dbz,
  input  logic                   div_ovf,
  input  logic [WIDTH-1:0]       div_q,
  input  logic [WIDTH-1:0]       div_r
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  if (N_REQ < 2 || N_REQ > 8 || FBITS < 0 || FBITS >= WIDTH || TIMEOUT < 1) begin : g_bad_params
    $error("fp_div_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [GW-1:0]      last_q, last_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [TW-1:0]      wdog_q, wdog_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [N_REQ-1:0]   rvalid_q, rvalid_d;
  logic [WIDTH-1:0]   quo_q, quo_d, rem_q, rem_d;
  logic [WIDTH-1:0]   dx_q, dx_d, dy_q, dy_d;
  logic               dbz_q, dbz_d, ovf_q, ovf_d, tmo_q, tmo_d;
  logic               busy_q, busy_d, start_q, start_d;

  logic [GW-1:0]      pick;
  logic [GW-1:0]      cand;
  logic               pick_vld;
  logic               done;

  // Search starts just after the last winner so every held request is reached within N_REQ grants.
  always_comb begin
    pick     = '0;
    cand     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = GW'((int'(last_q) + k) % N_REQ);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = grant_q;
    wdog_d   = wdog_q;
    ack_d    = '0;
    rvalid_d = '0;
    start_d  = 1'b0;
    busy_d   = busy_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    tmo_d    = tmo_q;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld && !div_busy) begin
          state_d     = S_WAIT;
          grant_d     = pick;
          ack_d[pick] = 1'b1;
          start_d     = 1'b1;
          busy_d      = 1'b1;
          wdog_d      = '0;
          dx_d        = req_x[int'(pick)*WIDTH +: WIDTH];
          dy_d        = req_y[int'(pick)*WIDTH +: WIDTH];
        end
      end
      S_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        // A valid coinciding with our own start belongs to an earlier operation.
        if (div_valid && !start_q) begin
          done  = 1'b1;
          quo_d = div_q;
          rem_d = div_r;
          dbz_d = div_dbz;
          ovf_d = div_ovf;
          tmo_d = 1'b0;
        end else if (wdog_q == TW'(TIMEOUT - 1)) begin
          done  = 1'b1;
          quo_d = '0;
          rem_d = '0;
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          tmo_d = 1'b1;
        end
        if (done) begin
          state_d           = S_RESP;
          rvalid_d[grant_q] = 1'b1;
          last_d            = grant_q;
          busy_d            = 1'b0;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      last_q   <= GW'(N_REQ - 1);
      grant_q  <= '0;
      wdog_q   <= '0;
      ack_q    <= '0;
      rvalid_q <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      wdog_q   <= wdog_d;
      ack_q    <= ack_d;
      rvalid_q <= rvalid_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
      tmo_q    <= tmo_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
    end
  end

  assign req_ack    = ack_q;
  assign resp_valid = rvalid_q;
  assign resp_q     = quo_q;
  assign resp_r     = rem_q;
  assign resp_dbz   = dbz_q;
  assign resp_ovf   = ovf_q;
  assign resp_tmo   = tmo_q;
  assign arb_busy   = busy_q;
  assign div_start  = start_q;
  assign div_x      = dx_q;
  assign div_y      = dy_q;

endmodule
